// File: rtl/fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue between busio and decode.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds misaligned-redirect fault reporting.
module fetch_queue #(
    parameter logic [31:0] RESET_VECTOR = 32'h00011100,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic [31:0] branch_vector,
    input  logic        trap,
    input  logic        mret,
    input  logic [31:0] trap_vector,
    input  logic [31:0] mret_vector,
    input  logic        stall,
    input  logic        invalidate,
    output logic        fetch_req,
    output logic [31:0] fetch_address,
    input  logic        fetch_ready,
    input  logic        fetch_rvalid,
    input  logic [31:0] fetch_data,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out,
    output logic        fault_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0] fetch_pc;
    logic [31:0] q_pc     [DEPTH];
    logic [31:0] q_data   [DEPTH];
    logic [31:0] pc_shadow[DEPTH];
    logic [AW-1:0] head, tail, sh_wr, sh_rd;
    logic [CW-1:0] count, inflight, drop;

    logic        redirect;
    logic [31:0] vector;
    logic        credit, accept, resp_keep, pop;
    logic        fault_emit, hold_fetch;
    logic [31:0] fault_pc;

    always_comb begin
        redirect = trap | mret | branch;
        vector   = branch_vector;
        if (trap)      vector = trap_vector;
        else if (mret) vector = mret_vector;
    end

    assign credit        = ({1'b0, count} + {1'b0, inflight}) < DEPTH_W;
    assign fetch_req     = !reset && !redirect && credit && !hold_fetch;
    assign fetch_address = fetch_pc;
    assign accept        = fetch_req && fetch_ready;
    assign resp_keep     = fetch_rvalid && (drop == '0) && !redirect;
    assign pop           = !redirect && !stall && !invalidate && !fault_emit && (count != '0);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned, fault_done, fault_reg;
    logic [31:0] fault_vec;

    // The flag is sticky until the next redirect; fault_done limits it to one emitted entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned <= 1'b0;
            fault_done <= 1'b0;
            fault_vec  <= '0;
            fault_reg  <= 1'b0;
        end else begin
            if (redirect) begin
                misaligned <= (vector[1:0] != 2'b00);
                fault_done <= 1'b0;
                fault_vec  <= vector;
            end else if (fault_emit) begin
                fault_done <= 1'b1;
            end
            if (!stall) fault_reg <= fault_emit;
        end
    end

    assign fault_emit = misaligned && !fault_done && (count == '0) && !redirect && !stall && !invalidate;
    assign hold_fetch = misaligned;
    assign fault_pc   = fault_vec;
    assign fault_out  = fault_reg;
`else
    assign fault_emit = 1'b0;
    assign hold_fetch = 1'b0;
    assign fault_pc   = '0;
    assign fault_out  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_VECTOR;
            head     <= '0;
            tail     <= '0;
            sh_wr    <= '0;
            sh_rd    <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            case ({accept, fetch_rvalid})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            if (accept)       sh_wr <= sh_wr + AW'(1);
            if (fetch_rvalid) sh_rd <= sh_rd + AW'(1);

            // Every request still outstanding after a redirect belongs to the old stream.
            if (redirect)
                drop <= fetch_rvalid ? inflight - CW'(1) : inflight;
            else if (fetch_rvalid && (drop != '0))
                drop <= drop - CW'(1);

            if (redirect) begin
                fetch_pc <= vector;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (accept)    fetch_pc <= fetch_pc + 32'd4;
                if (resp_keep) tail <= tail + AW'(1);
                if (pop)       head <= head + AW'(1);
                case ({resp_keep, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pc_shadow[sh_wr] <= fetch_pc;
        if (resp_keep) begin
            q_pc[tail]   <= pc_shadow[sh_rd];
            q_data[tail] <= fetch_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out       <= 1'b0;
            pc_out          <= '0;
            next_pc_out     <= '0;
            instruction_out <= '0;
        end else if (!stall) begin
            if (redirect || invalidate) begin
                valid_out <= 1'b0;
            end else if (fault_emit) begin
                valid_out       <= 1'b1;
                pc_out          <= fault_pc;
                next_pc_out     <= fault_pc + 32'd4;
                instruction_out <= NOP;
            end else if (pop) begin
                valid_out       <= 1'b1;
                pc_out          <= q_pc[head];
                next_pc_out     <= q_pc[head] + 32'd4;
                instruction_out <= q_data[head];
            end else begin
                valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a bus model feeds responses and a queue-based
// reference model tracks in-flight requests, the prefetch queue and the decode outputs.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h00011100;

    logic        clk, reset;
    logic        branch, trap, mret, stall, invalidate;
    logic [31:0] branch_vector, trap_vector, mret_vector;
    logic        fetch_req, fetch_ready, fetch_rvalid;
    logic [31:0] fetch_address, fetch_data;
    logic [31:0] pc_out, next_pc_out, instruction_out;
    logic        valid_out, fault_out;

    fetch_queue #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .branch(branch), .branch_vector(branch_vector),
        .trap(trap), .mret(mret), .trap_vector(trap_vector), .mret_vector(mret_vector),
        .stall(stall), .invalidate(invalidate),
        .fetch_req(fetch_req), .fetch_address(fetch_address), .fetch_ready(fetch_ready),
        .fetch_rvalid(fetch_rvalid), .fetch_data(fetch_data),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .instruction_out(instruction_out),
        .valid_out(valid_out), .fault_out(fault_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // reference model: instructions in the prefetch queue and requests on the bus
    typedef struct packed { logic [31:0] pc; logic [31:0] data; } entry_t;
    typedef struct packed { logic [31:0] pc; logic stale; } flight_t;
    entry_t  m_q[$];
    flight_t m_fl[$];
    logic [31:0] m_pc, m_pc_out, m_npc, m_instr;
    logic        m_valid;

    typedef struct { logic [31:0] addr; int due; } bus_t;
    bus_t bus_q[$];
    int   cyc = 0;
    int   n_acc = 0;

    int p_branch, p_trap, p_mret, p_stall, p_inv, p_ready, p_hold, lat_min, lat_max;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_0F13;
    endfunction

    function automatic logic [31:0] rand_vec();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0;
        return {$urandom(), 2'b00} >> 0 & 32'hFFFF_FFFC;
    endfunction

    task automatic set_knobs(input int br, input int tr, input int mr, input int st, input int inv,
                             input int rdy, input int hold, input int lmin, input int lmax);
        p_branch = br; p_trap = tr; p_mret = mr; p_stall = st; p_inv = inv;
        p_ready = rdy; p_hold = hold; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fl.delete();
        m_pc     = RV;
        m_valid  = 1'b0;
        m_pc_out = '0;
        m_npc    = '0;
        m_instr  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        branch = 0; trap = 0; mret = 0; stall = 0; invalidate = 0;
        fetch_ready = 0; fetch_rvalid = 0; fetch_data = '0;
        @(negedge clk);
        #1 check("req_in_reset", fetch_req, 1'b0);
        @(posedge clk);
        #1;
        bus_q.delete();
        model_reset();
        check("rst_valid", valid_out, 1'b0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_next_pc", next_pc_out, 32'h0);
        check("rst_instr", instruction_out, 32'h0);
        check("rst_fault", fault_out, 1'b0);
    endtask

    task automatic cycle();
        logic        redirect, exp_req, accept, rsp;
        logic [31:0] vec, rsp_data;
        flight_t     f;
        @(negedge clk);
        reset         = 1'b0;
        trap          = ($urandom_range(0, 99) < p_trap);
        mret          = ($urandom_range(0, 99) < p_mret);
        branch        = ($urandom_range(0, 99) < p_branch);
        trap_vector   = rand_vec();
        mret_vector   = rand_vec();
        branch_vector = rand_vec();
        stall         = ($urandom_range(0, 99) < p_stall);
        invalidate    = ($urandom_range(0, 99) < p_inv);
        fetch_ready   = ($urandom_range(0, 99) < p_ready);
        if (bus_q.size() > 0 && bus_q[0].due <= cyc && $urandom_range(0, 99) >= p_hold) begin
            fetch_rvalid = 1'b1;
            fetch_data   = word_of(bus_q[0].addr);
            void'(bus_q.pop_front());
        end else begin
            fetch_rvalid = 1'b0;
            fetch_data   = $urandom();
        end
        #1;
        redirect = trap | mret | branch;
        vec      = trap ? trap_vector : (mret ? mret_vector : branch_vector);
        exp_req  = !redirect && ((m_q.size() + m_fl.size()) < DEPTH);
        check("fetch_req", fetch_req, exp_req);
        if (exp_req) check("fetch_address", fetch_address, m_pc);
        if (fetch_req && fetch_ready) begin
            bus_q.push_back('{addr: fetch_address, due: cyc + $urandom_range(lat_min, lat_max)});
            n_acc++;
        end
        accept   = exp_req && fetch_ready;
        rsp      = fetch_rvalid;
        rsp_data = fetch_data;

        if (!stall) begin
            if (redirect || invalidate) begin
                m_valid = 1'b0;
            end else if (m_q.size() > 0) begin
                m_valid  = 1'b1;
                m_pc_out = m_q[0].pc;
                m_npc    = m_q[0].pc + 32'd4;
                m_instr  = m_q[0].data;
                void'(m_q.pop_front());
            end else begin
                m_valid = 1'b0;
            end
        end
        if (rsp && m_fl.size() > 0) begin
            f = m_fl.pop_front();
            if (!redirect && !f.stale) m_q.push_back('{pc: f.pc, data: rsp_data});
        end
        if (redirect) begin
            m_q.delete();
            foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            m_pc = vec;
        end else if (accept) begin
            m_fl.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        cyc++;

        @(posedge clk);
        #1;
        check("valid_out", valid_out, m_valid);
        check("pc_out", pc_out, m_pc_out);
        check("next_pc_out", next_pc_out, m_npc);
        check("instruction_out", instruction_out, m_instr);
        check("fault_out", fault_out, 1'b0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

`ifdef FETCH_MISALIGN_CHECK_EN
    task automatic misalign_test();
        int          n_valid;
        logic [31:0] seen_pc, seen_instr;
        logic        seen_fault;
        n_valid = 0; seen_pc = '0; seen_instr = '0; seen_fault = 1'b0;
        do_reset();
        @(negedge clk);
        reset = 1'b0; branch = 1'b1; branch_vector = 32'h0000_2002;
        fetch_ready = 1'b1; fetch_rvalid = 1'b0;
        #1 check("mis_req_redirect", fetch_req, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            branch = 1'b0;
            #1 check("mis_req", fetch_req, 1'b0);
            @(posedge clk);
            #1;
            if (valid_out) begin
                n_valid++;
                seen_pc = pc_out; seen_instr = instruction_out; seen_fault = fault_out;
            end
        end
        check("mis_valid_count", n_valid, 1);
        check("mis_pc", seen_pc, 32'h0000_2002);
        check("mis_instr", seen_instr, 32'h0000_0013);
        check("mis_fault", seen_fault, 1'b1);
    endtask
`endif

    initial begin
        reset = 1'b1;
        branch = 0; trap = 0; mret = 0; stall = 0; invalidate = 0;
        branch_vector = '0; trap_vector = '0; mret_vector = '0;
        fetch_ready = 0; fetch_rvalid = 0; fetch_data = '0;
        model_reset();
        do_reset();

        // streaming with one-cycle latency
        set_knobs(0, 0, 0, 0, 0, 100, 0, 1, 1);
        run(30);

        // responses withheld: only DEPTH requests may be accepted
        do_reset();
        set_knobs(0, 0, 0, 0, 0, 100, 100, 1, 1);
        n_acc = 0;
        run(10);
        check("withheld_accepts", n_acc, DEPTH);
        set_knobs(0, 0, 0, 0, 0, 100, 0, 1, 1);
        run(10);

        // long stall fills the queue, then it drains
        set_knobs(0, 0, 0, 100, 0, 100, 0, 1, 1);
        run(10);
        set_knobs(0, 0, 0, 0, 0, 100, 0, 1, 1);
        run(10);

        // redirect with requests in flight, then trap and branch together
        set_knobs(0, 0, 0, 0, 0, 100, 0, 3, 3);
        run(4);
        set_knobs(100, 0, 0, 0, 0, 100, 0, 3, 3);
        run(1);
        set_knobs(0, 0, 0, 0, 0, 100, 0, 1, 3);
        run(12);
        set_knobs(100, 100, 0, 0, 0, 100, 0, 1, 3);
        run(1);
        set_knobs(0, 0, 0, 0, 100, 100, 0, 1, 1);
        run(6);

        // fully random traffic with a mid-run reset
        set_knobs(5, 3, 3, 20, 10, 70, 10, 1, 4);
        run(300);
        do_reset();
        run(300);

`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_test();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
